// File: rtl/ins_fill_pkg.sv
// -----------------------------------------------------------------------------
// ins_fill_pkg
// Shared definitions for the instruction-cache line-fill engine:
//   - fill_state_e : fill controller states (IDLE, REQ, DONE)
//   - LINE_WORDS   : 32-bit words per cache line
//   - WORD_IDX_W   : width of the word index inside a line
//   - TIMER_W      : width of the per-word ack timeout counter
//   - word_addr()  : builds a word-aligned byte address from line + index
// -----------------------------------------------------------------------------
package ins_fill_pkg;

  localparam int LINE_WORDS  = 4;
  localparam int WORD_IDX_W  = 2;
  localparam int TIMER_W     = 8;
  localparam int WORD_W      = 32;
  localparam int LINE_W      = WORD_W * LINE_WORDS;
  // Byte address bits above the word index and byte offset.
  localparam int LINE_ADDR_W = 32 - WORD_IDX_W - 2;
  // Word counter needs one extra bit so it can reach LINE_WORDS.
  localparam int COUNT_W     = WORD_IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  function automatic logic [31:0] word_addr(input logic [LINE_ADDR_W-1:0] line,
                                            input logic [WORD_IDX_W-1:0]  idx);
    return {line, idx, 2'b00};
  endfunction

endpackage : ins_fill_pkg

// File: rtl/fill_timeout_ctr.sv
// -----------------------------------------------------------------------------
// fill_timeout_ctr
// Per-word ack timer for the line-fill engine. Counts cycles in which a word
// request is outstanding without an acknowledge.
//
// Parameters:
//   TIMEOUT_CYC : number of waiting cycles that constitutes a timeout (1..255)
// Ports:
//   clk    in  : clock, rising edge
//   rstn   in  : asynchronous active-low reset
//   clear  in  : synchronous clear (takes priority over enable)
//   enable in  : count this cycle (request outstanding, no ack)
//   expire out : this waiting cycle is the TIMEOUT_CYC-th one in a row
// -----------------------------------------------------------------------------
module fill_timeout_ctr
  import ins_fill_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TIMER_W-1:0] LAST_CNT = TIMER_W'(TIMEOUT_CYC - 1);

  logic [TIMER_W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // The counter holds the number of already-elapsed waiting cycles, so the
  // cycle in which it equals TIMEOUT_CYC-1 is the last one allowed. The owner
  // leaves the waiting state on expire, so the counter never wraps.
  assign expire = enable && !clear && (count == LAST_CNT);

endmodule : fill_timeout_ctr

// File: rtl/ins_line_fill.sv
// -----------------------------------------------------------------------------
// ins_line_fill
// Instruction-cache line-fill engine. On a fetch miss it reads the four words
// of the missed line from main memory, one request at a time, assembles them
// into a 128-bit line and pulses ovalid when the line is complete.
//
// Build option:
//   INS_LINE_FILL_CRITICAL_WORD_FIRST_EN
//     defined   : fetch starts at the missed word (ireq_addr[3:2]) and wraps
//     undefined : fetch always runs word 0,1,2,3
//   Either way each word lands in its own address slot of oline.
//
// Parameters:
//   TIMEOUT_CYC : max cycles waiting for imem_ack per word (1..255)
// Ports:
//   clk        in   1   clock, rising edge
//   rstn       in   1   asynchronous active-low reset
//   ireq       in   1   fetch miss: fill the line containing ireq_addr
//   ireq_addr  in   32  byte address of the missed instruction
//   iflush     in   1   abort an in-progress fill (taken branch)
//   omem_rd    out  1   word read request to main memory
//   omem_addr  out  32  word-aligned read address
//   imem_rdata in   32  read data, valid with imem_ack
//   imem_ack   in   1   read completes this cycle
//   oline      out  128 assembled line, word i at [32i+31:32i]
//   ovalid     out  1   one-cycle pulse: oline complete
//   obusy      out  1   fill in progress
//   oerr       out  1   one-cycle pulse: fill aborted by timeout
// -----------------------------------------------------------------------------
module ins_line_fill
  import ins_fill_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ireq,
  input  logic [31:0]       ireq_addr,
  input  logic              iflush,
  output logic              omem_rd,
  output logic [31:0]       omem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic [LINE_W-1:0] oline,
  output logic              ovalid,
  output logic              obusy,
  output logic              oerr
);

  fill_state_e              state;
  fill_state_e              state_nxt;
  logic [LINE_ADDR_W-1:0]   line;
  logic [WORD_IDX_W-1:0]    idx;
  logic [WORD_IDX_W-1:0]    start_idx;
  logic [COUNT_W-1:0]       count;
  logic [LINE_W-1:0]        line_data;
  logic                     err_pulse;
  logic                     accept;
  logic                     last_word;
  logic                     timer_clear;
  logic                     timer_enable;
  logic                     timer_expire;

  // ---------------------------------------------------------------------------
  // First word of the fill. The byte offset never matters; the word offset
  // only matters when fetching critical word first.
  // ---------------------------------------------------------------------------
`ifdef INS_LINE_FILL_CRITICAL_WORD_FIRST_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^ireq_addr[1:0];
  assign start_idx        = ireq_addr[3:2];
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^ireq_addr[3:0];
  assign start_idx        = '0;
`endif

  // A miss is accepted only from IDLE; a simultaneous flush wins.
  assign accept    = (state == IDLE) && ireq && !iflush;
  assign last_word = (count == COUNT_W'(LINE_WORDS - 1));

  // ---------------------------------------------------------------------------
  // Per-word timeout: counts REQ cycles without ack, restarts on every ack and
  // whenever the engine is not requesting.
  // ---------------------------------------------------------------------------
  assign timer_clear  = (state != REQ) || imem_ack;
  assign timer_enable = (state == REQ) && !imem_ack;

  fill_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of a combinational block keeps
  // every path assigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        // Flush aborts immediately and discards a same-cycle ack.
        if (iflush) begin
          state_nxt = IDLE;
        end else if (imem_ack && last_word) begin
          state_nxt = DONE;
        end else if (timer_expire) begin
          state_nxt = IDLE;
        end
      end
      DONE: begin
        // The completed line is reported regardless of a late flush.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fill datapath: request address, word bookkeeping and the line buffer.
  // ---------------------------------------------------------------------------
  // NOTE: the line buffer is a plain register bank, not a RAM, and must read
  // as zero straight out of reset, so it is reset along with the control state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line      <= '0;
      idx       <= '0;
      count     <= '0;
      line_data <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            line  <= ireq_addr[31:4];
            idx   <= start_idx;
            count <= '0;
          end
        end
        REQ: begin
          if (!iflush) begin
            if (imem_ack) begin
              // Words go to their address slot; slots not yet refilled keep
              // whatever the previous fill left there.
              for (int w = 0; w < LINE_WORDS; w++) begin
                if (idx == WORD_IDX_W'(w)) begin
                  line_data[WORD_W*w +: WORD_W] <= imem_rdata;
                end
              end
              idx   <= idx + 1'b1;
              count <= count + 1'b1;
            end else if (timer_expire) begin
              err_pulse <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The address is forced to zero outside REQ so idle reads as zero.
  // ---------------------------------------------------------------------------
  assign omem_rd   = (state == REQ);
  assign omem_addr = omem_rd ? word_addr(line, idx) : 32'd0;
  assign oline     = line_data;
  assign ovalid    = (state == DONE);
  assign obusy     = (state != IDLE);
  assign oerr      = err_pulse;

endmodule : ins_line_fill

// File: doc/ins_line_fill.md
INS_LINE_FILL -- requirements
Module: ins_line_fill

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: max cycles waiting for imem_ack per word, range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 ireq  input  1  fetch-stage miss: fill the line containing ireq_addr.
REQ-005 ireq_addr  input  32  byte address of missed instruction; [31:4] line, [3:2] word index.
REQ-006 iflush  input  1  abort in-progress fill (taken branch, PCSrc).
REQ-007 omem_rd  output  1  word read request to main memory.
REQ-008 omem_addr  output  32  word-aligned read address, [1:0]=0.
REQ-009 imem_rdata  input  32  read data, valid when imem_ack=1.
REQ-010 imem_ack  input  1  read completes this cycle.
REQ-011 oline  output  128  filled line; word i at [32i+31:32i]; feeds the instruction cache line input.
REQ-012 ovalid  output  1  one-cycle pulse: oline complete.
REQ-013 obusy  output  1  fill in progress (state != IDLE).
REQ-014 oerr  output  1  one-cycle pulse: fill aborted by timeout.

Function
REQ-015 States SHALL be IDLE, REQ, DONE.
REQ-016 IDLE: ireq=1 and iflush=0 at an edge SHALL latch ireq_addr[31:2], clear word count and timer, enter REQ; iflush=1 wins over ireq.
REQ-017 ireq while obusy=1 SHALL be ignored, with no queueing.
REQ-018 REQ: omem_rd=1, omem_addr={line,idx,2'b00}; idx and omem_addr SHALL stay stable until imem_ack.
REQ-019 imem_ack=1 in REQ SHALL write imem_rdata into oline word idx, advance idx by 1 modulo 4, increment count, and reset the timer.
REQ-020 The fourth ack SHALL move to DONE; omem_rd=0 in DONE.
REQ-021 DONE SHALL assert ovalid for exactly one cycle, then return to IDLE.
REQ-022 Back-to-back latency: with imem_ack=1 every REQ cycle and acceptance at edge N, words are captured at edges N+1..N+4 and ovalid is high in the cycle after N+4.
REQ-023 oline SHALL hold its value from DONE until the next accepted ireq; words not yet refilled keep old data, and oline is not valid without ovalid.
REQ-024 iflush=1 in REQ SHALL return to IDLE at that edge; a same-cycle imem_ack is discarded; no ovalid.
REQ-025 iflush=1 in DONE SHALL NOT suppress ovalid.
REQ-026 The timer SHALL count REQ cycles without ack; reaching TIMEOUT_CYC SHALL pulse oerr for one cycle and go to IDLE with no ovalid.
REQ-027 imem_ack outside REQ SHALL be ignored.

Reset
REQ-028 rstn=0 SHALL immediately force IDLE, with omem_rd=0, omem_addr=0, oline=0, ovalid=0, obusy=0, oerr=0, and count, idx and timer all 0, including mid-fill.
REQ-029 The first fill SHALL be accepted at the first edge after rstn deasserts.

Configuration
REQ-030 Macro INS_LINE_FILL_CRITICAL_WORD_FIRST_EN defined: the first fetched idx is ireq_addr[3:2], wrapping 3 -> 0.
REQ-031 Macro undefined: the first idx is always 0, fetched in order 0,1,2,3.
REQ-032 Both builds SHALL place each word at its address slot in oline.

Structure
REQ-033 Package ins_fill_pkg SHALL hold the state enum, LINE_WORDS=4, WORD_IDX_W=2, and TIMER_W=8.
REQ-034 Sub-module fill_timeout_ctr SHALL implement the per-word timer, with clear, enable and expire.

Verification
REQ-035 ireq with addr 0x0000_1008, imem_ack always 1 -> omem_addr 0x1000,0x1004,0x1008,0x100C; ovalid 5 cycles after accept (macro off).
REQ-036 Macro on, addr 0x0000_1008 -> addresses 0x1008,0x100C,0x1000,0x1004; rdata equal to address -> oline = {0x100C,0x1008,0x1004,0x1000}.
REQ-037 iflush after the 2nd ack -> IDLE next cycle, omem_rd=0, no ovalid; a new ireq is then accepted.
REQ-038 TIMEOUT_CYC=4, imem_ack held 0 -> oerr pulse after 4 REQ cycles, obusy=0, no ovalid.
REQ-039 rstn pulsed low mid-fill -> all outputs 0 immediately; a later ireq completes normally.
REQ-040 Second ireq while obusy=1 -> ignored; only one ovalid, with the first line's data.
